// File: rtl/alu_cmd_sequencer.sv
// Command/response front-end for the 8-bit combinational ALU. Registers a tagged
// command onto the ALU inputs, waits a fixed settle time, then captures the result
// and flags and returns them as a tagged response. Also tracks sticky flags and a
// saturating count of completed operations.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // command channel
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_opcode,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  input  logic [TAG_WIDTH-1:0]  i_cmd_tag,
  // ALU side
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [2:0]            o_alu_opcode,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  input  logic                  i_alu_negative,
  input  logic                  i_alu_overflow,
  // response channel
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_result,
  output logic [3:0]            o_rsp_flags,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag,
  // status
  output logic [3:0]            o_sticky_flags,
  input  logic                  i_sticky_clr,
  output logic [CNT_WIDTH-1:0]  o_op_count
);

  // Counter holds SETTLE_CYCLES-1 at most, so 4 bits cover the 1..15 range.
  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_d;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [2:0]            r_alu_opcode;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic [3:0]            r_rsp_flags;
  logic [3:0]            r_sticky;
  logic [3:0]            w_sticky_d;
  logic [CNT_WIDTH-1:0]  r_op_count;

  logic       w_accept;
  logic       w_capture;
  logic       w_rsp_done;
  logic       w_cmd_ready;
  logic       w_rsp_valid;
  logic [3:0] w_flags;

  assign w_flags = {i_alu_zero, i_alu_carry, i_alu_negative, i_alu_overflow};

  // Next-state, handshake strobes and state-only outputs (no path from rsp_ready to cmd_ready).
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      StIdle: begin
        w_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept  = 1'b1;
          w_cnt_d   = SettleInit;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StResp: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_rsp_done = 1'b1;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Sticky flags: a clear on the capture edge wipes old history before the new flags merge.
  always_comb begin
    w_sticky_d = r_sticky;
    if (i_sticky_clr) w_sticky_d = 4'b0000;
    if (w_capture)    w_sticky_d = w_sticky_d | w_flags;
  end

  // FSM state and settle counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Datapath registers: operands/tag on accept, result/flags on capture, status counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= 3'd0;
      r_tag        <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= 4'b0000;
      r_sticky     <= 4'b0000;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= i_cmd_a;
        r_alu_b      <= i_cmd_b;
        r_alu_opcode <= i_cmd_opcode;
        r_tag        <= i_cmd_tag;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_result;
        r_rsp_flags  <= w_flags;
      end
      r_sticky <= w_sticky_d;
      if (w_rsp_done && (r_op_count != {CNT_WIDTH{1'b1}})) begin
        r_op_count <= r_op_count + CNT_WIDTH'(1);
      end
    end
  end

  assign o_cmd_ready    = w_cmd_ready;
  assign o_rsp_valid    = w_rsp_valid;
  assign o_alu_a        = r_alu_a;
  assign o_alu_b        = r_alu_b;
  assign o_alu_opcode   = r_alu_opcode;
  // Tag register only changes on accept, so it is stable for the whole response.
  assign o_rsp_tag      = r_tag;
  assign o_rsp_result   = r_rsp_result;
  assign o_rsp_flags    = r_rsp_flags;
  assign o_sticky_flags = r_sticky;
  assign o_op_count     = r_op_count;

endmodule
